dct32_row_ctrl: RTL and testbench

DCT32_ROW_CTRL -- requirements
Module: dct32_row_ctrl

---
 rtl/dct_pkg.sv | 13 +
 rtl/dct_valid_pipe.sv | 32 +++
 rtl/dct32_row_ctrl.sv | 86 ++++++++
 tb/tb_dct32_row_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared definitions for the DCT32 row controller: FSM encoding and default sizing.
package dct_pkg;
  localparam int DEF_N_ROWS   = 32;
  localparam int DEF_PIPE_LAT = 6;
  localparam int DEF_CREDITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/dct_valid_pipe.sv
// Delay line that tracks {valid, row index} alongside the DCT datapath latency.
module dct_valid_pipe #(
  parameter int STAGES = 6,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [RW-1:0] in_row,
  output logic          out_vld,
  output logic [RW-1:0] out_row
);
  logic [STAGES-1:0]         vld_pipe;
  logic [STAGES-1:0][RW-1:0] row_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      row_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      row_pipe[0] <= in_row;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[STAGES-1];
  assign out_row = row_pipe[STAGES-1];
endmodule

// File: rtl/dct32_row_ctrl.sv
// Row sequencing controller for a 32-point DCT: accepts rows under downstream credit
// flow control, tracks them through the datapath latency and signals block completion.
module dct32_row_ctrl
  import dct_pkg::*;
#(
  parameter int N_ROWS   = DEF_N_ROWS,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int CREDITS  = DEF_CREDITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      dct_load,
  output logic                      out_valid,
  output logic [$clog2(N_ROWS)-1:0] out_row,
  output logic                      out_last,
  input  logic                      credit_ret,
  output logic                      done,
  output logic                      err_credit
);
  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);
  localparam logic [CW-1:0] CMAX     = CW'(CREDITS);

  state_e        state;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] credit_cnt;
  logic          accept;

  assign in_ready = (state == RUN) && (credit_cnt != '0);
  assign accept   = in_valid && in_ready;
  assign dct_load = accept;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      row_cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (start) begin
                 state   <= RUN;
                 row_cnt <= '0;
               end
        RUN:   if (accept) begin
                 row_cnt <= row_cnt + 1'b1;
                 if (row_cnt == LAST_ROW) state <= DRAIN;
               end
        DRAIN: if (out_valid && out_last) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A return that would overflow the buffer depth is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CMAX;
      err_credit <= 1'b0;
    end else begin
      case ({accept, credit_ret})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: if (credit_cnt == CMAX) err_credit <= 1'b1;
               else                    credit_cnt <= credit_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  dct_valid_pipe #(.STAGES(PIPE_LAT), .RW(RW)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (accept),
    .in_row  (row_cnt),
    .out_vld (out_valid),
    .out_row (out_row)
  );

  assign out_last = out_valid && (out_row == LAST_ROW);
endmodule

// File: tb/tb_dct32_row_ctrl.sv
// Self-checking bench for dct32_row_ctrl: scoreboard on the output row stream plus
// a cycle table for credit stall, recovery and simultaneous-event behaviour.
module tb_dct32_row_ctrl;
  import dct_pkg::*;
  localparam int NR = DEF_N_ROWS;
  localparam int PL = DEF_PIPE_LAT;
  localparam int CR = DEF_CREDITS;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, credit_ret = 1'b0;
  logic       busy, in_ready, dct_load, out_valid, out_last, done, err_credit;
  logic [4:0] out_row;

  dct32_row_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .dct_load(dct_load), .out_valid(out_valid),
    .out_row(out_row), .out_last(out_last), .credit_ret(credit_ret),
    .done(done), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int due; } sb_t;
  typedef struct { logic iv; logic cr; logic rdy; int cred; } vec_t;

  sb_t  sb[$];
  vec_t vt[17];
  int   n_chk = 0, n_pass = 0, cyc = 0, exp_row = 0, n_acc = 0, n_done = 0;
  int   last_cyc = -100, d0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // One clock: handshake check and scoreboard push before the edge, output check after.
  task automatic step();
    logic acc;
    sb_t  e;
    #1;
    acc = in_valid && in_ready;
    chk("dct_load", dct_load, acc);
    if (acc) begin
      e.row = exp_row; e.due = cyc + PL;
      sb.push_back(e);
      exp_row++; n_acc++;
    end
    @(posedge clk); cyc++; #1;
    if (out_valid) begin
      if (sb.size() == 0) fail("spurious out_valid");
      else begin
        e = sb.pop_front();
        chk("out_row", out_row, e.row);
        chk("out_last", out_last, (e.row == NR - 1));
        chk("out_latency", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      fail("missing out_valid");
      void'(sb.pop_front());
    end
    chk("done", done, (cyc == last_cyc + 1));
    if (done) n_done++;
    if (out_valid && out_last) last_cyc = cyc;
  endtask

  task automatic do_start();
    start = 1'b1; exp_row = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    in_valid = 1'b0; start = 1'b0; credit_ret = 1'b0;
    while (busy && k < 200) begin step(); k++; end
    chk("drain_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vt[i] = '{1'b1, 1'b0, 1'b1, 7 - i};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 0};
    vt[13] = '{1'b0, 1'b1, 1'b0, 1};
    vt[14] = '{1'b0, 1'b1, 1'b1, 2};
    vt[15] = '{1'b0, 1'b1, 1'b1, 3};
    vt[16] = '{1'b1, 1'b1, 1'b1, 3};

    // reset state
    #12;
    chk("rst_busy", busy, 0);       chk("rst_in_ready", in_ready, 0);
    chk("rst_dct_load", dct_load, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0); chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);       chk("rst_err", err_credit, 0);
    chk("rst_credit", dut.credit_cnt, CR);
    rst = 1'b1;

    // nominal block with one credit return per row starting at the fourth row
    do_start();
    chk("nom_busy", busy, 1);
    n_acc = 0;
    for (int i = 0; i < NR; i++) begin
      in_valid = 1'b1; credit_ret = (i >= 3);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin credit_ret = 1'b1; step(); end
    credit_ret = 1'b0;
    chk("nom_accepts", n_acc, NR);
    d0 = n_done;
    wait_idle();
    chk("nom_done_pulses", n_done - d0, 1);
    chk("nom_credit", dut.credit_cnt, CR);
    chk("nom_err", err_credit, 0);

    // credit stall, recovery, simultaneous accept + return
    do_start();
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = vt[i].iv; credit_ret = vt[i].cr;
      #1;
      chk("tbl_in_ready", in_ready, vt[i].rdy);
      step();
      chk("tbl_credit", dut.credit_cnt, vt[i].cred);
      if (i == 9)  chk("stall_accepts", n_acc, 8);
      if (i == 12) chk("recover_accepts", n_acc, 9);
    end
    chk("tbl_accepts", n_acc, 10);
    for (int k = 0; exp_row < NR && k < 100; k++) begin
      in_valid = 1'b1; credit_ret = 1'b1; step();
    end
    in_valid = 1'b0; credit_ret = 1'b0;
    chk("blk2_rows", exp_row, NR);
    chk("blk2_credit", dut.credit_cnt, 3);
    wait_idle();
    chk("blk2_credit_idle", dut.credit_cnt, 3);
    for (int i = 0; i < 5; i++) begin credit_ret = 1'b1; step(); end
    credit_ret = 1'b0;
    chk("refill_credit", dut.credit_cnt, CR);
    chk("refill_err", err_credit, 0);
    credit_ret = 1'b1; step(); credit_ret = 1'b0;
    chk("ovf_err", err_credit, 1);
    chk("ovf_credit", dut.credit_cnt, CR);
    repeat (3) step();
    chk("ovf_err_sticky", err_credit, 1);

    // in_valid while idle is ignored
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_in_ready", in_ready, 0);
      chk("idle_load", dct_load, 0);
      step();
    end
    in_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_row_cnt", dut.row_cnt, 0);
    chk("idle_credit", dut.credit_cnt, CR);

    // start during RUN is ignored
    do_start();
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; credit_ret = 1'b1; step(); end
    in_valid = 1'b0; credit_ret = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("run_start_busy", busy, 1);
    chk("run_start_state", dut.state, RUN);
    chk("run_start_row_cnt", dut.row_cnt, 5);
    for (int k = 0; exp_row < 11 && k < 50; k++) begin
      in_valid = 1'b1; credit_ret = 1'b1; step();
    end
    credit_ret = 1'b0;
    chk("mid_rows", exp_row, 11);

    // asynchronous reset mid-block with in_valid still high
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);       chk("mrst_in_ready", in_ready, 0);
    chk("mrst_dct_load", dct_load, 0); chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_row", out_row, 0); chk("mrst_out_last", out_last, 0);
    chk("mrst_done", done, 0);       chk("mrst_err", err_credit, 0);
    sb.delete();
    @(posedge clk); cyc++; #1;
    in_valid = 1'b0; rst = 1'b1; last_cyc = -100; d0 = n_done;
    repeat (20) step();
    chk("mrst_no_done", n_done - d0, 0);
    chk("mrst_idle", busy, 0);
    chk("mrst_credit", dut.credit_cnt, CR);
    chk("mrst_row_cnt", dut.row_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
